intersection_sched: RTL and testbench
=====================================

INTERSECTION_SCHED -- requirements
Module: intersection_sched

Interface
REQ-001 The module SHALL have parameter LONG_CYC, default 8, meaning the minimum highway-green and maximum farm-green dwell in cycles (legal range 1..255).
REQ-002 The module SHALL have parameter SHORT_CYC, default 2, meaning the yellow dwell in cycles (legal range 1..255).
REQ-003 The module SHALL have parameter WALK_CYC, default 4, meaning the all-red pedestrian dwell in cycles (legal range 1..255).
REQ-004 The module SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port reset, input, width 1: reset, asynchronous and active-high.
REQ-006 The module SHALL have port c, input, width 1: farm-road car sensor, level, sampled each edge, not latched.
REQ-007 The module SHALL have port ped_req, input, width 1: pedestrian button, latched internally.
REQ-008 The module SHALL have port hl, output, width 2: highway light code.
REQ-009 The module SHALL have port fl, output, width 2: farm light code.
REQ-010 The module SHALL have port walk, output, width 1: pedestrian walk lamp.
REQ-011 The module SHALL have port ped_pend, output, width 1: latched pedestrian request.
REQ-012 The module SHALL have port state_o, output, width 3: current state code, for debug.

Function
REQ-013 The module SHALL implement states HG, HY, FG, FY and WALK with codes 0..4.
- Light codes: GREEN=0, YELLOW=1, RED=2.
REQ-014 All outputs SHALL be registered and decoded from state only (Moore):
- HG: hl=GREEN, fl=RED.
- HY: hl=YELLOW, fl=RED.
- FG: hl=RED, fl=GREEN.
- FY: hl=RED, fl=YELLOW.
- WALK: hl=RED, fl=RED, walk=1.
- walk=0 in every other state.
REQ-015 An 8-bit dwell counter cnt SHALL clear to 0 on the edge of every state transition and otherwise increment, saturating at 255.
REQ-016 HG SHALL move to HY at the edge where cnt>=LONG_CYC-1 and (c or ped_pend); otherwise HG SHALL hold indefinitely.
REQ-017 HY SHALL last exactly SHORT_CYC cycles, then go to WALK if ped_pend=1, else to FG.
REQ-018 FG SHALL move to FY at the first edge where c=0 or cnt==LONG_CYC-1, whichever comes first.
REQ-019 FY SHALL last exactly SHORT_CYC cycles, then go to WALK if ped_pend=1, else to HG.
REQ-020 WALK SHALL last exactly WALK_CYC cycles, then always go to HG.
REQ-021 ped_pend SHALL set on the edge after ped_req=1 is sampled and clear on the edge that enters WALK.
- When set and clear coincide, clear SHALL win.
- ped_req sampled while in WALK SHALL be ignored.
REQ-022 A c pulse that is not high at the qualifying HG edge SHALL have no effect.
REQ-023 No state SHALL ever drive GREEN or YELLOW on both roads simultaneously.

Reset
REQ-024 Asserting reset SHALL immediately force, at any point including mid-dwell:
- state=HG, cnt=0, ped_pend=0.
- hl=GREEN, fl=RED, walk=0, state_o=0.
REQ-025 After reset deasserts, the first HG dwell SHALL count from cnt=0.

Structure
REQ-026 Package traffic_pkg SHALL hold the following, and no other block-specific content:
- the state enum;
- the light-code typedef and constants GREEN/YELLOW/RED.
REQ-027 The dwell counter SHALL be a sub-module interval_timer.
- Inputs: clk, reset, clr.
- Output: 8-bit cnt.
REQ-028 The FSM, pedestrian latch and output decode SHALL reside in intersection_sched.

Verification (defaults LONG=8, SHORT=2, WALK=4; cycle 0 = first edge after reset release)
REQ-029 Idle: c=0, ped_req=0 for 30 cycles -> HG throughout; hl=0, fl=2, walk=0.
REQ-030 c held 1 from cycle 0 -> sequence HG(8), HY(2), FG(8), FY(2), HG.
REQ-031 c=1 from cycle 0, dropped at the 3rd FG cycle -> FG lasts 3 cycles, then FY(2), then HG.
REQ-032 Single-cycle ped_req at cycle 2, c=0 -> sequence:
- ped_pend=1 from cycle 3;
- HG(8), HY(2);
- WALK(4) with walk=1, hl=fl=2, and ped_pend=0 from WALK entry;
- then HG.
REQ-033 c=1 plus ped_req pulse at cycle 1 -> sequence HG(8), HY(2), WALK(4), HG(8), HY(2), FG.
REQ-034 reset pulse during FG cycle 4 -> same-cycle outputs: hl=0, fl=2, state_o=0, ped_pend=0; first HY no earlier than 8 cycles after release.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared state and light-code definitions for the intersection scheduler.
// Latency: n/a (types only).
// Backpressure: n/a.
package traffic_pkg;

  typedef enum logic [2:0] {
    HG   = 3'd0,
    HY   = 3'd1,
    FG   = 3'd2,
    FY   = 3'd3,
    WALK = 3'd4
  } state_t;

  typedef logic [1:0] light_t;

  localparam light_t GREEN  = 2'd0;
  localparam light_t YELLOW = 2'd1;
  localparam light_t RED    = 2'd2;

endpackage

// File: rtl/interval_timer.sv
// Dwell counter: clears on clr, otherwise counts up and sticks at 255.
// Latency: cnt updates one edge after clr/increment is sampled.
// Backpressure: none.
module interval_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  output logic [7:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (cnt != 8'hff) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/intersection_sched.sv
// Highway/farm-road light scheduler with a latched pedestrian all-red phase.
// Latency: lights are registered and follow the state register on the same edge.
// Backpressure: none; inputs are sampled every edge.
module intersection_sched
  import traffic_pkg::*;
#(
  parameter int LONG_CYC  = 8,
  parameter int SHORT_CYC = 2,
  parameter int WALK_CYC  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       c,
  input  logic       ped_req,
  output logic [1:0] hl,
  output logic [1:0] fl,
  output logic       walk,
  output logic       ped_pend,
  output logic [2:0] state_o
);

  localparam logic [7:0] LONG_LAST  = 8'(LONG_CYC - 1);
  localparam logic [7:0] SHORT_LAST = 8'(SHORT_CYC - 1);
  localparam logic [7:0] WALK_LAST  = 8'(WALK_CYC - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic       clr;
  logic       enter_walk;
  logic       ped_pend_nxt;
  light_t     hl_nxt;
  light_t     fl_nxt;
  logic       walk_nxt;

  interval_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .cnt   (cnt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      HG:      if (cnt >= LONG_LAST && (c || ped_pend)) state_nxt = HY;
      HY:      if (cnt == SHORT_LAST) state_nxt = ped_pend ? WALK : FG;
      FG:      if (!c || cnt == LONG_LAST) state_nxt = FY;
      FY:      if (cnt == SHORT_LAST) state_nxt = ped_pend ? WALK : HG;
      WALK:    if (cnt == WALK_LAST) state_nxt = HG;
      default: state_nxt = HG;
    endcase
  end

  assign clr        = (state_nxt != state);
  assign enter_walk = (state_nxt == WALK) && (state != WALK);

  // Entering WALK serves the request, so the clear beats a coincident press.
  always_comb begin
    ped_pend_nxt = ped_pend;
    if (enter_walk) begin
      ped_pend_nxt = 1'b0;
    end else if (ped_req && state != WALK) begin
      ped_pend_nxt = 1'b1;
    end
  end

  always_comb begin
    hl_nxt   = RED;
    fl_nxt   = RED;
    walk_nxt = 1'b0;
    case (state_nxt)
      HG:      hl_nxt = GREEN;
      HY:      hl_nxt = YELLOW;
      FG:      fl_nxt = GREEN;
      FY:      fl_nxt = YELLOW;
      WALK:    walk_nxt = 1'b1;
      default: hl_nxt = RED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= HG;
      ped_pend <= 1'b0;
      hl       <= GREEN;
      fl       <= RED;
      walk     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ped_pend <= ped_pend_nxt;
      hl       <= hl_nxt;
      fl       <= fl_nxt;
      walk     <= walk_nxt;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_intersection_sched.sv
// Bench for intersection_sched: per-cycle behavioural model plus literal dwell-run checks.
module tb_intersection_sched;

  localparam int LONG  = 8;
  localparam int SHORT = 2;
  localparam int WLK   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       c;
  logic       ped_req;
  logic [1:0] hl;
  logic [1:0] fl;
  logic       walk;
  logic       ped_pend;
  logic [2:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  intersection_sched dut (
    .clk      (clk),
    .reset    (reset),
    .c        (c),
    .ped_req  (ped_req),
    .hl       (hl),
    .fl       (fl),
    .walk     (walk),
    .ped_pend (ped_pend),
    .state_o  (state_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // Model: state 0..4 = HG,HY,FG,FY,WALK; m_t = cycles already spent in the state.
  int m_st, m_t, m_nx;
  bit m_pend;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st = 0; m_t = 0; m_pend = 1'b0;
    end else begin
      m_nx = m_st;
      case (m_st)
        0: if (m_t >= LONG - 1 && (c || m_pend)) m_nx = 1;
        1: if (m_t + 1 == SHORT) m_nx = m_pend ? 4 : 2;
        2: if (!c || m_t + 1 == LONG) m_nx = 3;
        3: if (m_t + 1 == SHORT) m_nx = m_pend ? 4 : 0;
        default: if (m_t + 1 == WLK) m_nx = 0;
      endcase
      if (m_nx == 4 && m_st != 4) m_pend = 1'b0;
      else if (ped_req && m_st != 4) m_pend = 1'b1;
      m_t  = (m_nx != m_st) ? 0 : m_t + 1;
      m_st = m_nx;
    end
  end

  // Completed runs of (state, length), for DUT and model separately.
  int run_st[$], run_len[$], mrun_st[$], mrun_len[$];
  int cur_st, cur_len, mcur_st, mcur_len;

  always @(negedge clk) begin
    if (chk_en) begin
      check("hl",       hl,       (m_st == 0) ? 0 : (m_st == 1) ? 1 : 2);
      check("fl",       fl,       (m_st == 2) ? 0 : (m_st == 3) ? 1 : 2);
      check("walk",     walk,     (m_st == 4) ? 1 : 0);
      check("ped_pend", ped_pend, m_pend);
      check("state_o",  state_o,  m_st);
      check("conflict", (hl != 2'd2) && (fl != 2'd2), 0);
    end
    if (reset) begin
      run_st.delete(); run_len.delete(); mrun_st.delete(); mrun_len.delete();
      cur_st = 0; cur_len = 0; mcur_st = 0; mcur_len = 0;
    end else begin
      if (int'(state_o) == cur_st) cur_len++;
      else begin
        run_st.push_back(cur_st); run_len.push_back(cur_len);
        cur_st = int'(state_o); cur_len = 1;
      end
      if (m_st == mcur_st) mcur_len++;
      else begin
        mrun_st.push_back(mcur_st); mrun_len.push_back(mcur_len);
        mcur_st = m_st; mcur_len = 1;
      end
    end
  end

  task automatic check_run(input string name, input int idx, input int st, input int len);
    check({name, "_dut_st"},   (idx < run_st.size())   ? run_st[idx]   : -1, st);
    check({name, "_dut_len"},  (idx < run_len.size())  ? run_len[idx]  : -1, len);
    check({name, "_mdl_st"},   (idx < mrun_st.size())  ? mrun_st[idx]  : -1, st);
    check({name, "_mdl_len"},  (idx < mrun_len.size()) ? mrun_len[idx] : -1, len);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench just after a release edge; the next edge is cycle 0.
  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1; c = 1'b0; ped_req = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; c = 1'b0; ped_req = 1'b0;
    #2;
    check("rst_hl", hl, 0);
    check("rst_fl", fl, 2);
    check("rst_walk", walk, 0);
    check("rst_state", state_o, 0);
    check("rst_pend", ped_pend, 0);
    chk_en = 1'b1;

    // Idle, then a single c sample long after the counter has saturated.
    do_reset();
    tick(30);
    check("idle_runs", run_st.size(), 0);
    check("idle_state", state_o, 0);
    tick(228);
    c = 1'b1; tick(1); c = 1'b0;
    tick(10);
    check_run("sat0", 0, 0, 259);
    check_run("sat1", 1, 1, SHORT);
    check_run("sat2", 2, 2, 1);
    check_run("sat3", 3, 3, SHORT);

    // c held high: full cycle through the farm road.
    do_reset();
    c = 1'b1;
    tick(24);
    check_run("c_hi0", 0, 0, 8);
    check_run("c_hi1", 1, 1, 2);
    check_run("c_hi2", 2, 2, 8);
    check_run("c_hi3", 3, 3, 2);
    check("c_hi_state", state_o, 0);

    // c drops during the 3rd farm-green cycle.
    do_reset();
    c = 1'b1;
    tick(12);
    c = 1'b0;
    tick(12);
    check_run("c_drop0", 0, 0, 8);
    check_run("c_drop1", 1, 1, 2);
    check_run("c_drop2", 2, 2, 3);
    check_run("c_drop3", 3, 3, 2);
    check("c_drop_state", state_o, 0);

    // Pedestrian press at cycle 2; a second press during WALK is ignored.
    do_reset();
    tick(2);
    ped_req = 1'b1;
    @(negedge clk); #1;
    check("ped_before", ped_pend, 0);
    @(posedge clk); #1 ped_req = 1'b0;
    @(negedge clk); #1;
    check("ped_latched", ped_pend, 1);
    tick(8);
    ped_req = 1'b1; tick(1); ped_req = 1'b0;
    tick(12);
    check_run("ped0", 0, 0, 8);
    check_run("ped1", 1, 1, 2);
    check_run("ped2", 2, 4, 4);
    check("ped_nruns", run_st.size(), 3);
    check("ped_state", state_o, 0);
    check("ped_after", ped_pend, 0);

    // c high plus press at cycle 1.
    do_reset();
    c = 1'b1;
    tick(1);
    ped_req = 1'b1; tick(1); ped_req = 1'b0;
    tick(28);
    check_run("cped0", 0, 0, 8);
    check_run("cped1", 1, 1, 2);
    check_run("cped2", 2, 4, 4);
    check_run("cped3", 3, 0, 8);
    check_run("cped4", 4, 1, 2);
    check("cped_state", state_o, 2);

    // Reset in the middle of farm green.
    do_reset();
    c = 1'b1;
    tick(14);
    check("mid_fg", state_o, 2);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_hl", hl, 0);
    check("mid_rst_fl", fl, 2);
    check("mid_rst_state", state_o, 0);
    check("mid_rst_pend", ped_pend, 0);
    check("mid_rst_walk", walk, 0);
    tick(1);
    reset = 1'b0;
    tick(12);
    check_run("post_rst0", 0, 0, 8);
    check_run("post_rst1", 1, 1, 2);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
